// File: rtl/onchip_ram_burst_slave.sv
`default_nettype none
// ============================================================================
// Module   : onchip_ram_burst_slave
// Brief    : Parametrised on-chip RAM behind an Avalon-MM pipelined burst slave.
// Revision : 1.0 - initial release
// ============================================================================
module onchip_ram_burst_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 11,
    parameter int BURST_WIDTH = 4,
    parameter int OUTPUT_REG  = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    input  logic                      read,
    input  logic                      write,
    input  logic [DATA_WIDTH-1:0]     writedata,
    input  logic [BURST_WIDTH-1:0]    burstcount,
    input  logic                      clken,
    output logic                      waitrequest,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic                      readdatavalid
);

    localparam int c_BYTES     = DATA_WIDTH / 8;
    localparam int c_DEPTH     = 1 << ADDR_WIDTH;
    localparam int c_MAX_BURST = 1 << (BURST_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RBURST = 2'd1,
        WBURST = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [BURST_WIDTH-1:0]  r_remaining;
    logic [BURST_WIDTH-1:0]  w_len;
    logic                    w_idle;
    logic                    w_cmd_wr;
    logic                    w_cmd_rd;
    logic                    w_beat_wr;
    logic                    w_beat_rd;
    logic                    w_last;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic [ADDR_WIDTH-1:0]   w_ram_addr;
    logic [DATA_WIDTH-1:0]   r_ram_q;
    logic                    r_rd_v1;
    logic                    w_valid_out;

    (* ram_init_file = INIT_FILE *)
    logic [DATA_WIDTH-1:0]   r_mem [0:c_DEPTH-1];

    // Burst length normalisation: 0 means a single beat, oversize saturates.
    always_comb begin
        if (burstcount == '0)
            w_len = BURST_WIDTH'(1);
        else if (burstcount > BURST_WIDTH'(c_MAX_BURST))
            w_len = BURST_WIDTH'(c_MAX_BURST);
        else
            w_len = burstcount;
    end

    assign w_idle     = (r_state == IDLE);
    assign w_cmd_wr   = reset_n & clken & w_idle & write;
    assign w_cmd_rd   = reset_n & clken & w_idle & read & ~write;
    assign w_beat_wr  = reset_n & clken & (r_state == WBURST) & write;
    assign w_beat_rd  = reset_n & clken & (r_state == RBURST);
    assign w_last     = (r_remaining == BURST_WIDTH'(1));
    assign w_wr_en    = w_cmd_wr | w_beat_wr;
    assign w_rd_en    = w_cmd_rd | w_beat_rd;
    assign w_ram_addr = w_idle ? address : r_addr;

    assign waitrequest = ~reset_n | ~clken | (r_state == RBURST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd_wr)
                    w_state_nxt = (w_len > BURST_WIDTH'(1)) ? WBURST : IDLE;
                else if (w_cmd_rd && (w_len > BURST_WIDTH'(1)))
                    w_state_nxt = RBURST;
            end
            RBURST: if (w_beat_rd && w_last) w_state_nxt = IDLE;
            WBURST: if (w_beat_wr && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (w_cmd_wr || w_cmd_rd) begin
            r_addr      <= address + ADDR_WIDTH'(1);
            r_remaining <= w_len - BURST_WIDTH'(1);
        end else if (w_beat_wr || w_beat_rd) begin
            r_addr      <= r_addr + ADDR_WIDTH'(1);
            r_remaining <= r_remaining - BURST_WIDTH'(1);
        end
    end

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (byteenable[b])
                    r_mem[w_ram_addr][b*8 +: 8] <= writedata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ram_q <= '0;
        else if (w_rd_en)
            r_ram_q <= r_mem[w_ram_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_rd_v1 <= 1'b0;
        else if (clken)
            r_rd_v1 <= w_rd_en;
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_q2;
            logic                  r_v2;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_q2 <= '0;
                    r_v2 <= 1'b0;
                end else if (clken) begin
                    r_v2 <= r_rd_v1;
                    if (r_rd_v1)
                        r_q2 <= r_ram_q;
                end
            end

            assign readdata    = r_q2;
            assign w_valid_out = r_v2;
        end else begin : g_no_out_reg
            assign readdata    = r_ram_q;
            assign w_valid_out = r_rd_v1;
        end
    endgenerate

    // A stalled beat stays parked in the pipeline and is shown once clken returns.
    assign readdatavalid = w_valid_out & clken;

endmodule
`default_nettype wire
